shift_serializer_ctrl: RTL and testbench

//  Sequencer for the right-shift register in the serial TX path. It accepts a word-send

---
 rtl/shift_serializer_ctrl.sv | 128 ++++++++++++
 tb/tb_shift_serializer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer_ctrl.sv
// Sequencer for the TX right-shift register: it issues the load and shift strobes and flags valid serial bits.
// Optional feature macro SHIFT_CTRL_ABORT_EN adds an abort input and an aborted pulse output.
module shift_serializer_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int SHIFT_DIV   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_valid,
  output logic                           start_ready,
`ifdef SHIFT_CTRL_ABORT_EN
  input  logic                           abort,
  output logic                           aborted,
`endif
  output logic                           load,
  output logic                           shift,
  output logic                           bit_valid,
  output logic [$clog2(WORD_LENGTH)-1:0] bit_index,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = $clog2(WORD_LENGTH);
  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               term_cnt;
  logic               last_bit;

`ifdef SHIFT_CTRL_ABORT_EN
  logic               aborted_q, aborted_d;
`endif

  // Handshake: a word is accepted on a cycle where start_valid && start_ready are both high;
  // start_ready depends only on state, and start_valid seen outside IDLE is dropped, never queued.

  // With SHIFT_DIV == 1 the divider is never incremented, so it stays a constant 0.
  assign term_cnt = (div_q == DIV_W'(SHIFT_DIV - 1));
  assign last_bit = (idx_q == IDX_W'(WORD_LENGTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
    end
  end

`ifdef SHIFT_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
`ifdef SHIFT_CTRL_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) state_d = LOAD;
      end
      LOAD: begin
        idx_d   = '0;
        div_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (term_cnt) begin
          // The final bit is presented but never shifted out of the register.
          if (last_bit) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            div_d = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SHIFT_CTRL_ABORT_EN
    // Abort overrides the terminal-count transition evaluated above.
    if (abort && (state_q == LOAD || state_q == SEND)) begin
      state_d   = IDLE;
      idx_d     = '0;
      div_d     = '0;
      aborted_d = 1'b1;
    end
`endif
  end

  assign start_ready = (state_q == IDLE);
  assign load        = (state_q == LOAD);
  assign bit_valid   = (state_q == SEND);
  assign shift       = (state_q == SEND) && term_cnt && !last_bit;
  assign busy        = (state_q == LOAD) || (state_q == SEND);
  assign done        = (state_q == DONE);
  assign bit_index   = idx_q;
  assign dbg_state   = state_q;
`ifdef SHIFT_CTRL_ABORT_EN
  assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Bench for shift_serializer_ctrl: two instances (SHIFT_DIV 1 and 4), event scoreboard per instance.
// Expected strobe events are pushed with their cycle stamps; a negedge monitor pops and compares.
module tb_shift_serializer_ctrl;

  localparam int WL  = 8;
  localparam int BIG = 1 << 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       sv    [2];
  logic       rdy   [2];
  logic       ld    [2];
  logic       sh    [2];
  logic       bv    [2];
  logic [2:0] bidx  [2];
  logic       bsy   [2];
  logic       dn    [2];
  logic [1:0] st    [2];
`ifdef SHIFT_CTRL_ABORT_EN
  logic       ab    [2];
  logic       abd   [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_serializer_ctrl #(.WORD_LENGTH(WL), .SHIFT_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(sv[0]), .start_ready(rdy[0]),
`ifdef SHIFT_CTRL_ABORT_EN
    .abort(ab[0]), .aborted(abd[0]),
`endif
    .load(ld[0]), .shift(sh[0]), .bit_valid(bv[0]), .bit_index(bidx[0]),
    .busy(bsy[0]), .done(dn[0]), .dbg_state(st[0])
  );

  shift_serializer_ctrl #(.WORD_LENGTH(WL), .SHIFT_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start_valid(sv[1]), .start_ready(rdy[1]),
`ifdef SHIFT_CTRL_ABORT_EN
    .abort(ab[1]), .aborted(abd[1]),
`endif
    .load(ld[1]), .shift(sh[1]), .bit_valid(bv[1]), .bit_index(bidx[1]),
    .busy(bsy[1]), .done(dn[1]), .dbg_state(st[1])
  );

  // Event kinds: 0 load, 1 bit_valid(+index), 2 shift, 3 done, 4 start_ready rise, 5 aborted
  function automatic logic [31:0] mk(input int k, input int idx, input int c);
    logic [2:0]  kk = k[2:0];
    logic [3:0]  ii = idx[3:0];
    logic [24:0] cc = c[24:0];
    return {kk, ii, cc};
  endfunction

  task automatic push_ev(input int u, input int k, input int idx, input int c, input int cut);
    if (c < cut) exp_q[u].push_back(mk(k, idx, c));
  endtask

  // Expected events for a word accepted on cycle t; cut is the first cycle cleared by reset/abort.
  task automatic push_word(input int u, input int t, input int cut, input bit abrt);
    int d;
    d = (u == 0) ? 1 : 4;
    push_ev(u, 0, 0, t + 1, cut);
    for (int s = 0; s < WL * d; s++) begin
      push_ev(u, 1, s / d, t + 2 + s, cut);
      if ((s % d == d - 1) && (s / d < WL - 1)) push_ev(u, 2, 0, t + 2 + s, cut);
    end
    push_ev(u, 3, 0, t + 2 + WL * d, cut);
    push_ev(u, 4, 0, t + 3 + WL * d, cut);
    if (cut < BIG) begin
      exp_q[u].push_back(mk(4, 0, cut));
      if (abrt) exp_q[u].push_back(mk(5, 0, cut));
    end
  endtask

  task automatic sb_check(input int u, input logic [31:0] act, input string name);
    logic [31:0] exp;
    checks++;
    if (exp_q[u].size() == 0) begin
      errors++;
      $display("FAIL %s dut%0d: got event %h, expected no event", name, u, act);
    end else begin
      exp = exp_q[u].pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s dut%0d: got event %h, expected %h", name, u, act, exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic rdy_prev [2];
    rdy_prev[0] = 1'b1;
    rdy_prev[1] = 1'b1;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (ld[u])  sb_check(u, mk(0, 0, cyc), "load");
        if (bv[u])  sb_check(u, mk(1, int'(bidx[u]), cyc), "bit_valid");
        if (sh[u])  sb_check(u, mk(2, 0, cyc), "shift");
        if (dn[u])  sb_check(u, mk(3, 0, cyc), "done");
        if (rdy[u] && !rdy_prev[u]) sb_check(u, mk(4, 0, cyc), "start_ready");
`ifdef SHIFT_CTRL_ABORT_EN
        if (abd[u]) sb_check(u, mk(5, 0, cyc), "aborted");
`endif
        rdy_prev[u] = rdy[u];
      end
    end
  end

  initial begin : driver
    int t;
    int c;
    reset = 1'b0;
    sv[0] = 1'b0;
    sv[1] = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
    ab[0] = 1'b0;
    ab[1] = 1'b0;
`endif
    // Reset state: {start_ready, load, shift, bit_valid, busy, done, bit_index}
    wait_cycles(3);
    for (int u = 0; u < 2; u++)
      chk($sformatf("reset_outputs dut%0d", u),
          32'({rdy[u], ld[u], sh[u], bv[u], bsy[u], dn[u], bidx[u]}), 32'b1_00000_000);
    #1 reset = 1'b1;
    wait_cycles(2);

    // Single word, SHIFT_DIV=1
    t = cyc;
    sv[0] = 1'b1;
    push_word(0, t, BIG, 1'b0);
    next_cycle();
    sv[0] = 1'b0;
    wait_cycles(12);

    // Single word, SHIFT_DIV=4, with start_valid toggling during SEND
    t = cyc;
    sv[1] = 1'b1;
    push_word(1, t, BIG, 1'b0);
    next_cycle();
    sv[1] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      sv[1] = i[0];
    end
    sv[1] = 1'b0;
    wait_cycles(20);

    // start_valid held high: accepts at t, t+11, t+22
    t = cyc;
    sv[0] = 1'b1;
    push_word(0, t, BIG, 1'b0);
    push_word(0, t + 11, BIG, 1'b0);
    push_word(0, t + 22, BIG, 1'b0);
    wait_cycles(23);
    sv[0] = 1'b0;
    wait_cycles(12);

    // Reset asserted mid-SEND at bit_index 3
    t = cyc;
    c = t + 5;
    sv[0] = 1'b1;
    push_word(0, t, c, 1'b0);
    next_cycle();
    sv[0] = 1'b0;
    while (cyc < c) next_cycle();
    #1 reset = 1'b0;
    #1 chk("async_reset_clear", 32'({rdy[0], ld[0], sh[0], bv[0], bsy[0], dn[0], bidx[0]}),
           32'b1_00000_000);
    next_cycle();
    reset = 1'b1;
    wait_cycles(2);
    t = cyc;
    sv[0] = 1'b1;
    push_word(0, t, BIG, 1'b0);
    next_cycle();
    sv[0] = 1'b0;
    wait_cycles(12);

`ifdef SHIFT_CTRL_ABORT_EN
    // Abort at bit_index 5
    t = cyc;
    sv[0] = 1'b1;
    push_word(0, t, t + 8, 1'b1);
    next_cycle();
    sv[0] = 1'b0;
    while (cyc < t + 7) next_cycle();
    ab[0] = 1'b1;
    next_cycle();
    ab[0] = 1'b0;
    wait_cycles(12);
`endif

    wait_cycles(3);
    for (int u = 0; u < 2; u++)
      chk($sformatf("events_left dut%0d", u), 32'(exp_q[u].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
